vr_hw2_mem_dma: RTL and testbench

VR_HW2_MEM_DMA -- requirements
Module: vr_hw2_mem_dma

---
 rtl/vr_hw2_mem_dma_if.sv | 29 ++
 rtl/vr_hw2_mem_dma.sv | 171 +++++++++++++++++
 tb/tb_vr_hw2_mem_dma.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vr_hw2_mem_dma_if.sv
// Bus bundle for the word-copy / fill DMA engine: control request,
// status and the single-port memory interface.
interface vr_hw2_mem_dma_if #(
   parameter int LEN_W = 9
);
   logic             START;
   logic [31:0]      SRC;
   logic [31:0]      DST;
   logic [LEN_W-1:0] LEN;
   logic             FILL;
   logic [31:0]      PAT;
   logic [31:0]      ADDR;
   logic             RW;
   logic [31:0]      WD;
   logic [31:0]      RD;
   logic             BUSY;
   logic             DONE;
   logic             ERR;

   modport slave (
      input  START, SRC, DST, LEN, FILL, PAT, RD,
      output ADDR, RW, WD, BUSY, DONE, ERR
   );

   modport master (
      output START, SRC, DST, LEN, FILL, PAT, RD,
      input  ADDR, RW, WD, BUSY, DONE, ERR
   );
endinterface

// File: rtl/vr_hw2_mem_dma.sv
// Word-granular memory-to-memory DMA with optional pattern fill.
// Optional feature macro: VR_HW2_MEM_DMA_FILL_EN (fill mode; copy-only when undefined).
//
// state | meaning
// IDLE  | waiting for START, memory outputs parked at zero
// RD    | reading one word at the source pointer
// WR    | writing the data register to the destination pointer
// FIN   | single DONE cycle before returning to IDLE
//
// All memory outputs are registered: the bounds check for an access is done
// on the edge that would launch it, so an out-of-range address is never driven.
module vr_hw2_mem_dma #(
   parameter int MEM_BYTES = 1024,
   parameter int LEN_W     = 9
) (
   input logic               CLK,
   input logic               RST,
   vr_hw2_mem_dma_if.slave   bus
);

   localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   state_t           state;
   logic [31:0]      src_q;
   logic [31:0]      dst_q;
   logic [LEN_W-1:0] cnt_q;
   logic [31:0]      data_q;
   logic             fill_q;

   logic             fill_start;
   logic [31:0]      src_next;
   logic [31:0]      dst_next;
   logic [LEN_W-1:0] cnt_next;

`ifdef VR_HW2_MEM_DMA_FILL_EN
   assign fill_start = bus.FILL;
`else
   logic unused_fill;
   assign fill_start  = 1'b0;
   assign unused_fill = bus.FILL;
`endif

   // Next pointer/count values used when leaving RD or WR.
   always_comb begin
      src_next = src_q + 32'd4;
      dst_next = dst_q + 32'd4;
      cnt_next = cnt_q - LEN_W'(1);
   end

   // Transfer sequencer with registered memory and status outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= S_IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         cnt_q    <= '0;
         data_q   <= '0;
         fill_q   <= 1'b0;
         bus.ADDR <= '0;
         bus.RW   <= 1'b0;
         bus.WD   <= '0;
         bus.BUSY <= 1'b0;
         bus.DONE <= 1'b0;
         bus.ERR  <= 1'b0;
      end else begin
         bus.DONE <= 1'b0;
         bus.ERR  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.START) begin
                  src_q  <= bus.SRC;
                  dst_q  <= bus.DST;
                  cnt_q  <= bus.LEN;
                  fill_q <= fill_start;
                  data_q <= bus.PAT;
                  if ((bus.SRC[1:0] != 2'b00) || (bus.DST[1:0] != 2'b00)) begin
                     bus.ERR <= 1'b1;
                  end else if (bus.LEN == '0) begin
                     state    <= S_FIN;
                     bus.BUSY <= 1'b1;
                     bus.DONE <= 1'b1;
                  end else if (fill_start) begin
                     if (bus.DST >= MEM_LIMIT) begin
                        bus.ERR <= 1'b1;
                     end else begin
                        state    <= S_WR;
                        bus.BUSY <= 1'b1;
                        bus.ADDR <= bus.DST;
                        bus.RW   <= 1'b1;
                        bus.WD   <= bus.PAT;
                     end
                  end else if (bus.SRC >= MEM_LIMIT) begin
                     bus.ERR <= 1'b1;
                  end else begin
                     state    <= S_RD;
                     bus.BUSY <= 1'b1;
                     bus.ADDR <= bus.SRC;
                  end
               end
            end

            S_RD: begin
               data_q <= bus.RD;
               src_q  <= src_next;
               if (dst_q >= MEM_LIMIT) begin
                  state    <= S_IDLE;
                  bus.BUSY <= 1'b0;
                  bus.ERR  <= 1'b1;
                  bus.ADDR <= '0;
                  bus.RW   <= 1'b0;
                  bus.WD   <= '0;
               end else begin
                  state    <= S_WR;
                  bus.ADDR <= dst_q;
                  bus.RW   <= 1'b1;
                  bus.WD   <= bus.RD;
               end
            end

            S_WR: begin
               dst_q <= dst_next;
               cnt_q <= cnt_next;
               if (cnt_next == '0) begin
                  state    <= S_FIN;
                  bus.DONE <= 1'b1;
                  bus.ADDR <= '0;
                  bus.RW   <= 1'b0;
                  bus.WD   <= '0;
               end else if (fill_q ? (dst_next >= MEM_LIMIT) : (src_q >= MEM_LIMIT)) begin
                  state    <= S_IDLE;
                  bus.BUSY <= 1'b0;
                  bus.ERR  <= 1'b1;
                  bus.ADDR <= '0;
                  bus.RW   <= 1'b0;
                  bus.WD   <= '0;
               end else if (fill_q) begin
                  bus.ADDR <= dst_next;
                  bus.RW   <= 1'b1;
                  bus.WD   <= data_q;
               end else begin
                  state    <= S_RD;
                  bus.ADDR <= src_q;
                  bus.RW   <= 1'b0;
                  bus.WD   <= '0;
               end
            end

            S_FIN: begin
               state    <= S_IDLE;
               bus.BUSY <= 1'b0;
            end

            default: begin
               state    <= S_IDLE;
               bus.BUSY <= 1'b0;
               bus.ADDR <= '0;
               bus.RW   <= 1'b0;
               bus.WD   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vr_hw2_mem_dma.sv
// Self-checking bench for vr_hw2_mem_dma: directed table, hand-written
// multi-cycle sequences and randomized transfers against a word-level model.
module tb_vr_hw2_mem_dma;

   localparam int MEM = 1024;
   localparam int LW  = 9;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   vr_hw2_mem_dma_if #(.LEN_W(LW)) bus ();

   vr_hw2_mem_dma #(.MEM_BYTES(MEM), .LEN_W(LW)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   logic [31:0] mem     [256];
   logic [31:0] exp_mem [256];

   assign bus.RD = mem[bus.ADDR[9:2]];

   int checks   = 0;
   int failures = 0;

   int st_busy, st_done, st_err, st_both, st_oob, st_idle_bad;
   int st_rw, st_run, st_rw_max;
   logic last_busy;

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      logic [8:0]  len;
      logic        fill;
      logic [31:0] pat;
      int          busy;
      int          done;
      int          err;
      int          rw;
      int          rwrun;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic clr_stats();
      st_busy = 0; st_done = 0; st_err = 0; st_both = 0; st_oob = 0;
      st_idle_bad = 0; st_rw = 0; st_run = 0; st_rw_max = 0; last_busy = 1'b0;
   endtask

   // Sample one cycle at the falling edge, perform the pending write, advance.
   task automatic tick();
      if (bus.BUSY) st_busy++;
      if (bus.DONE) st_done++;
      if (bus.ERR) st_err++;
      if (bus.DONE && bus.ERR) st_both++;
      if (bus.BUSY && (bus.ADDR >= 32'(MEM))) st_oob++;
      if ((!bus.BUSY || bus.DONE) && (bus.ADDR != 0 || bus.RW || bus.WD != 0)) st_idle_bad++;
      if (bus.RW) begin
         st_rw++;
         st_run++;
         if (st_run > st_rw_max) st_rw_max = st_run;
         if (bus.ADDR < 32'(MEM)) mem[bus.ADDR[9:2]] = bus.WD;
      end else begin
         st_run = 0;
      end
      last_busy = bus.BUSY;
      @(negedge CLK);
   endtask

   // Word-level reference: applies the transfer to exp_mem in ascending order.
   task automatic model_xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                             input logic fill, input logic [31:0] pat,
                             output int busy, output int done, output int err, output int wr);
      logic f;
      logic [31:0] s, d;
`ifdef VR_HW2_MEM_DMA_FILL_EN
      f = fill;
`else
      f = 1'b0;
      if (fill) f = 1'b0;
`endif
      busy = 0; done = 0; err = 0; wr = 0;
      if (src[1:0] != 0 || dst[1:0] != 0) begin
         err = 1;
         return;
      end
      for (int i = 0; i < len; i++) begin
         s = src + 32'(4 * i);
         d = dst + 32'(4 * i);
         if (!f) begin
            if (s >= 32'(MEM)) begin err = 1; return; end
            busy++;
         end
         if (d >= 32'(MEM)) begin err = 1; return; end
         exp_mem[d[9:2]] = f ? pat : exp_mem[s[9:2]];
         busy++;
         wr++;
      end
      done = 1;
      busy++;
   endtask

   task automatic cmp_mem(input string name);
      int diffs;
      diffs = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) diffs++;
      check(name, 32'(diffs), 32'd0);
   endtask

   // Issue START at the falling edge and run until the transfer has ended.
   // second_at >= 0 injects a second START with other parameters mid-transfer.
   task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input logic [8:0] len,
                           input logic fill, input logic [31:0] pat, input int second_at);
      logic fin;
      clr_stats();
      fin = 1'b0;
      bus.SRC = src; bus.DST = dst; bus.LEN = len; bus.FILL = fill; bus.PAT = pat;
      bus.START = 1'b1;
      tick();
      bus.START = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (k == second_at) begin
            bus.SRC = 32'h0; bus.DST = 32'h2C0; bus.LEN = 9'd2; bus.FILL = 1'b0;
            bus.START = 1'b1;
         end
         tick();
         bus.START = 1'b0;
         if ((st_done + st_err) > 0 && !last_busy) begin
            fin = 1'b1;
            break;
         end
      end
      check("xfer_timeout", {31'd0, fin}, 32'd1);
   endtask

   function automatic logic [31:0] pick_addr();
      int v;
      v = int'($urandom_range(0, 99));
      if (v < 6) return 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
      if (v < 18) return 32'($urandom_range(250, 260)) * 4;
      if (v < 20) return 32'hFFFF_FFFC;
      return 32'($urandom_range(0, 255)) * 4;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int mb, md, me, mw, wr_seen;
      logic [31:0] rs, rd_a, rp;
      logic [8:0] rl;
      logic rf;

      bus.START = 1'b0; bus.SRC = '0; bus.DST = '0; bus.LEN = '0; bus.FILL = 1'b0; bus.PAT = '0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      for (int i = 0; i < 4; i++) mem[i] = 32'hA000_0000 + 32'(i);

      // Table: {src, dst, len, fill, pat, busy, done, err, rw, rwrun}
      vecs[0] = '{32'h000, 32'h100, 9'd4, 1'b0, 32'h0, 9, 1, 0, 4, 1};
      vecs[1] = '{32'h000, 32'h040, 9'd0, 1'b0, 32'h0, 1, 1, 0, 0, 0};
      vecs[2] = '{32'h002, 32'h100, 9'd4, 1'b0, 32'h0, 0, 0, 1, 0, 0};
      vecs[3] = '{32'h3F8, 32'h000, 9'd4, 1'b0, 32'h0, 4, 0, 1, 2, 1};
`ifdef VR_HW2_MEM_DMA_FILL_EN
      vecs[4] = '{32'h020, 32'h200, 9'd3, 1'b1, 32'hDEADBEEF, 4, 1, 0, 3, 3};
`else
      vecs[4] = '{32'h020, 32'h200, 9'd3, 1'b1, 32'hDEADBEEF, 7, 1, 0, 3, 1};
`endif
      vecs[5] = '{32'h000, 32'h101, 9'd2, 1'b0, 32'h0, 0, 0, 1, 0, 0};
      vecs[6] = '{32'h000, 32'h3FC, 9'd2, 1'b0, 32'h0, 3, 0, 1, 1, 1};
      vecs[7] = '{32'h400, 32'h000, 9'd1, 1'b0, 32'h0, 0, 0, 1, 0, 0};
      vecs[8] = '{32'h080, 32'h084, 9'd3, 1'b0, 32'h0, 7, 1, 0, 3, 1};

      // Reset state while RST is held.
      #2;
      check("rst_addr", bus.ADDR, 32'h0);
      check("rst_rw",   {31'd0, bus.RW}, 32'h0);
      check("rst_wd",   bus.WD, 32'h0);
      check("rst_busy", {31'd0, bus.BUSY}, 32'h0);
      check("rst_done", {31'd0, bus.DONE}, 32'h0);
      check("rst_err",  {31'd0, bus.ERR}, 32'h0);
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);

      for (int i = 0; i < 9; i++) begin
         exp_mem = mem;
         model_xfer(vecs[i].src, vecs[i].dst, int'(vecs[i].len), vecs[i].fill, vecs[i].pat, mb, md, me, mw);
         run_xfer(vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].fill, vecs[i].pat, -1);
         check($sformatf("vec%0d_busy", i),  32'(st_busy), 32'(vecs[i].busy));
         check($sformatf("vec%0d_done", i),  32'(st_done), 32'(vecs[i].done));
         check($sformatf("vec%0d_err", i),   32'(st_err), 32'(vecs[i].err));
         check($sformatf("vec%0d_rw", i),    32'(st_rw), 32'(vecs[i].rw));
         check($sformatf("vec%0d_rwrun", i), 32'(st_rw_max), 32'(vecs[i].rwrun));
         check($sformatf("vec%0d_oob", i),   32'(st_oob + st_both + st_idle_bad), 32'd0);
         cmp_mem($sformatf("vec%0d_mem", i));
         if (i == 0)
            for (int j = 0; j < 4; j++)
               check($sformatf("copy_word%0d", j), mem[8'h40 + 8'(j)], 32'hA000_0000 + 32'(j));
`ifdef VR_HW2_MEM_DMA_FILL_EN
         if (i == 4)
            for (int j = 0; j < 3; j++)
               check($sformatf("fill_word%0d", j), mem[8'h80 + 8'(j)], 32'hDEADBEEF);
`endif
      end

      // Second START while busy is ignored.
      exp_mem = mem;
      model_xfer(32'h010, 32'h280, 4, 1'b0, 32'h0, mb, md, me, mw);
      run_xfer(32'h010, 32'h280, 9'd4, 1'b0, 32'h0, 2);
      check("busy_start_done", 32'(st_done), 32'd1);
      check("busy_start_err",  32'(st_err), 32'd0);
      check("busy_start_busy", 32'(st_busy), 32'd9);
      check("busy_start_rw",   32'(st_rw), 32'd4);
      cmp_mem("busy_start_mem");
      for (int k = 0; k < 4; k++) tick();
      check("busy_start_quiet", 32'(st_done + st_err + st_busy), 32'd1 + 32'd9);

      // Reset asserted during the third write of an 8-word copy.
      exp_mem = mem;
      for (int j = 0; j < 2; j++) exp_mem[8'hC0 + 8'(j)] = exp_mem[j];
      clr_stats();
      wr_seen = 0;
      bus.SRC = 32'h0; bus.DST = 32'h300; bus.LEN = 9'd8; bus.FILL = 1'b0;
      bus.START = 1'b1;
      tick();
      bus.START = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (bus.RW && wr_seen == 2) break;
         if (bus.RW) wr_seen++;
         tick();
      end
      check("rst_mid_reached", 32'(wr_seen), 32'd2);
      #1 RST = 1'b1;
      #1;
      check("rst_mid_rw",   {31'd0, bus.RW}, 32'h0);
      check("rst_mid_addr", bus.ADDR, 32'h0);
      check("rst_mid_wd",   bus.WD, 32'h0);
      check("rst_mid_busy", {31'd0, bus.BUSY}, 32'h0);
      check("rst_mid_flag", {30'd0, bus.DONE, bus.ERR}, 32'h0);
      @(negedge CLK);
      RST = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      check("rst_mid_nodone", 32'(st_done + st_err), 32'd0);
      cmp_mem("rst_mid_mem");

      // Randomized transfers against the model.
      for (int r = 0; r < 40; r++) begin
         rs = pick_addr();
         rd_a = pick_addr();
         rl = 9'($urandom_range(0, 10));
         rf = 1'($urandom_range(0, 1));
         rp = $urandom;
         exp_mem = mem;
         model_xfer(rs, rd_a, int'(rl), rf, rp, mb, md, me, mw);
         run_xfer(rs, rd_a, rl, rf, rp, -1);
         check($sformatf("rnd%0d_busy", r), 32'(st_busy), 32'(mb));
         check($sformatf("rnd%0d_done", r), 32'(st_done), 32'(md));
         check($sformatf("rnd%0d_err", r),  32'(st_err), 32'(me));
         check($sformatf("rnd%0d_rw", r),   32'(st_rw), 32'(mw));
         check($sformatf("rnd%0d_oob", r),  32'(st_oob + st_both + st_idle_bad), 32'd0);
         cmp_mem($sformatf("rnd%0d_mem", r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
